iic_bus_arbiter: RTL
====================

Name: iic_bus_arbiter

Overview:
- Round-robin arbiter/sequencer that shares one transaction-level I2C master engine (the bus driver used by the LM75A temperature path) among NREQ requesters, e.g. the temperature poller and a configuration writer.
- Accepts one whole transaction per requester: device address, direction, 1 or 2 data bytes.
- Issues it to the master and returns read data and status to the owning requester.
- Runs a watchdog that aborts a hung transaction.

Parameters:
- NREQ, 2, number of requesters (2..4).
- TIMEOUT, 4096, maximum clk cycles in WAIT before abort (>=2).
- TW, 13, timeout counter width; 2^TW > TIMEOUT.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- req  in  NREQ  per-requester transaction request, level, held until matching done.
- req_addr  in  7*NREQ  7-bit device address per requester, slice i at [7i+6:7i].
- req_rw  in  NREQ  1=read, 0=write.
- req_len2  in  NREQ  1=two data bytes, 0=one byte.
- req_wdata  in  16*NREQ  write data, MSB byte sent first; one-byte write uses [15:8].
- done  out  NREQ  one-cycle completion pulse to owning requester.
- err  out  1  valid with done: NACK or timeout.
- rdata  out  16  valid with done; one-byte read returns {byte,8'h00}.
- grant  out  NREQ  one-hot owner, high from ISSUE through RESP.
- m_start  out  1  one-cycle command strobe to master.
- m_addr  out  7, m_rw out 1, m_len2 out 1, m_wdata out 16  latched command, stable from ISSUE until RESP.
- m_abort  out  1  one-cycle abort strobe (master releases bus, issues STOP).
- m_busy  in  1  master engaged.
- m_done  in  1  one-cycle transaction-complete pulse.
- m_ack_err  in  1  valid with m_done: address or data NACK.
- m_rdata  in  16  valid with m_done.

Behaviour:
- Reset:
  - All outputs 0, FSM IDLE, timeout counter 0.
  - last_grant = NREQ-1, so requester 0 wins first.
  - Reset mid-transaction drops the transaction silently: no done, no m_abort.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req bit is high, pick the first set bit searching from last_grant+1 with wrap.
  - Latch its addr/rw/len2/wdata into m_* and set grant one-hot.
  - Next state ISSUE. With no req, stay IDLE.
- ISSUE:
  - If m_busy=0, assert m_start for exactly this cycle, then go to WAIT.
  - If m_busy=1, hold in ISSUE with no strobe.
- WAIT:
  - Counter increments each cycle.
  - On m_done: capture m_ack_err into err and m_rdata into rdata, then go to RESP.
  - If the counter reaches TIMEOUT-1 without m_done: pulse m_abort, set err=1, rdata=0, go to RESP.
  - m_done and timeout in the same cycle: m_done wins, no abort.
- RESP:
  - done[g] pulses for one cycle; err/rdata are valid that cycle and hold until the next RESP.
  - last_grant = g, grant cleared, counter cleared, next state IDLE.
- Latency: req high in IDLE at cycle t gives m_start at t+1 (if not busy), and done one cycle after m_done.
- Request dropped mid-transaction: ignored. Command stays latched, transaction completes, done is still pulsed.
- A requester re-asserting in the cycle after done competes normally. It has the lowest priority if others are requesting.
- m_done outside WAIT: ignored.
- Fairness: continuous requests from all requesters are served strictly in rotation (0,1,...,NREQ-1,0).

Decomposition:
- Shared package iic_pkg holds:
  - FSM state encoding;
  - LM75A_ADDR = 7'b1001000;
  - the command field widths (7/1/1/16).
- One sub-module, iic_rr_pick: combinational round-robin priority picker (req, last_grant -> one-hot grant, any).
- The FSM, counter and latches stay in the top module.

Test Plan:
- Single read: req[0], addr 7'h48, rw=1, len2=1; master returns m_rdata=16'hA7CA, m_ack_err=0 -> m_start 1 cycle after req, m_addr=7'h48, then done=2'b01 with rdata=16'hA7CA and err=0.
- Simultaneous requests after reset: req=2'b11, both held -> grants alternate 01,10,01; no two grants overlap; done pulses in the same order.
- Write then NACK: req[1] write addr 7'h48, wdata 16'h0100, len2=0; master returns m_ack_err=1 -> done=2'b10 with err=1 and m_wdata=16'h0100.
- Timeout: TIMEOUT=16, master never pulses m_done -> m_abort on the 16th WAIT cycle, then done with err=1 and rdata=0; the next request is served normally.
- Busy master: m_busy=1 for 5 cycles at ISSUE -> m_start delayed until the first cycle m_busy=0, command fields unchanged.
- Reset mid-WAIT: reset during WAIT -> next cycle all outputs 0 with no done/m_abort; a following req[1] alone is granted, and req=2'b11 grants 0 first.

Source files
------------

// File: rtl/iic_pkg.sv
// Shared definitions for the I2C master arbiter: FSM encoding, command field
// widths and the LM75A device address.
package iic_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   localparam int ADDR_W = 7;
   localparam int RW_W   = 1;
   localparam int LEN_W  = 1;
   localparam int DATA_W = 16;

   localparam logic [ADDR_W-1:0] LM75A_ADDR = 7'b1001000;

endpackage

// File: rtl/iic_rr_pick.sv
// Combinational round-robin picker: first set request bit searching upward
// from last_grant+1 with wrap-around.
module iic_rr_pick #(
   parameter int NREQ = 2,
   parameter int IW   = 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   last_grant,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   idx,
   output logic            any
);

   always_comb begin
      any   = |req;
      grant = '0;
      idx   = '0;
      // Scan farthest offset first so the closest requester overwrites last.
      for (int off = NREQ; off >= 1; off--) begin
         if (req[(int'(last_grant) + off) % NREQ]) begin
            grant = '0;
            grant[(int'(last_grant) + off) % NREQ] = 1'b1;
            idx   = IW'((int'(last_grant) + off) % NREQ);
         end
      end
   end

endmodule

// File: rtl/iic_bus_arbiter.sv
// Round-robin sequencer sharing one transaction-level I2C master among NREQ
// requesters, with a watchdog that aborts a hung transaction.
module iic_bus_arbiter
   import iic_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int TIMEOUT = 4096,
   parameter int TW      = 13
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req,
   input  logic [ADDR_W*NREQ-1:0]   req_addr,
   input  logic [NREQ-1:0]          req_rw,
   input  logic [NREQ-1:0]          req_len2,
   input  logic [DATA_W*NREQ-1:0]   req_wdata,
   output logic [NREQ-1:0]          done,
   output logic                     err,
   output logic [DATA_W-1:0]        rdata,
   output logic [NREQ-1:0]          grant,
   output logic                     m_start,
   output logic [ADDR_W-1:0]        m_addr,
   output logic                     m_rw,
   output logic                     m_len2,
   output logic [DATA_W-1:0]        m_wdata,
   output logic                     m_abort,
   input  logic                     m_busy,
   input  logic                     m_done,
   input  logic                     m_ack_err,
   input  logic [DATA_W-1:0]        m_rdata
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_t              state_reg;
   logic [TW-1:0]       count_reg;
   logic [IW-1:0]       last_grant_reg;
   logic [IW-1:0]       owner_reg;
   logic [NREQ-1:0]     grant_reg;
   logic [NREQ-1:0]     done_reg;
   logic                err_reg;
   logic [DATA_W-1:0]   rdata_reg;
   logic [ADDR_W-1:0]   m_addr_reg;
   logic                m_rw_reg;
   logic                m_len2_reg;
   logic [DATA_W-1:0]   m_wdata_reg;

   logic [NREQ-1:0]     pick_grant;
   logic [IW-1:0]       pick_idx;
   logic                pick_any;
   logic                timeout_hit;

   logic [ADDR_W-1:0]   addr_arr  [NREQ];
   logic [DATA_W-1:0]   wdata_arr [NREQ];

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_slice
         assign addr_arr[gi]  = req_addr[ADDR_W*gi +: ADDR_W];
         assign wdata_arr[gi] = req_wdata[DATA_W*gi +: DATA_W];
      end
   endgenerate

   iic_rr_pick #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_pick (
      .req        (req),
      .last_grant (last_grant_reg),
      .grant      (pick_grant),
      .idx        (pick_idx),
      .any        (pick_any)
   );

   assign timeout_hit = (count_reg == TW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= ST_IDLE;
         count_reg      <= '0;
         last_grant_reg <= IW'(NREQ - 1);
         owner_reg      <= '0;
         grant_reg      <= '0;
         done_reg       <= '0;
         err_reg        <= 1'b0;
         rdata_reg      <= '0;
         m_addr_reg     <= '0;
         m_rw_reg       <= 1'b0;
         m_len2_reg     <= 1'b0;
         m_wdata_reg    <= '0;
      end else begin
         done_reg <= '0;
         case (state_reg)
            ST_IDLE: begin
               if (pick_any) begin
                  grant_reg   <= pick_grant;
                  owner_reg   <= pick_idx;
                  m_addr_reg  <= addr_arr[pick_idx];
                  m_rw_reg    <= req_rw[pick_idx];
                  m_len2_reg  <= req_len2[pick_idx];
                  m_wdata_reg <= wdata_arr[pick_idx];
                  state_reg   <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (!m_busy) state_reg <= ST_WAIT;
            end
            ST_WAIT: begin
               // A completion in the same cycle as the watchdog expiry wins.
               if (m_done) begin
                  err_reg   <= m_ack_err;
                  rdata_reg <= m_rdata;
                  done_reg  <= grant_reg;
                  state_reg <= ST_RESP;
               end else if (timeout_hit) begin
                  err_reg   <= 1'b1;
                  rdata_reg <= '0;
                  done_reg  <= grant_reg;
                  state_reg <= ST_RESP;
               end else begin
                  count_reg <= count_reg + TW'(1);
               end
            end
            ST_RESP: begin
               last_grant_reg <= owner_reg;
               grant_reg      <= '0;
               count_reg      <= '0;
               state_reg      <= ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   // Strobes depend on this cycle's m_busy/m_done so they cannot be registered.
   assign m_start = (state_reg == ST_ISSUE) && !m_busy;
   assign m_abort = (state_reg == ST_WAIT) && !m_done && timeout_hit;

   assign done    = done_reg;
   assign err     = err_reg;
   assign rdata   = rdata_reg;
   assign grant   = grant_reg;
   assign m_addr  = m_addr_reg;
   assign m_rw    = m_rw_reg;
   assign m_len2  = m_len2_reg;
   assign m_wdata = m_wdata_reg;

endmodule
